// File: rtl/tri_frame_scheduler_pkg.sv
// Shared types and sizing for the per-frame triangle scheduler and its camera latch.
package tri_frame_scheduler_pkg;

  localparam int unsigned NUM_TRI      = 2048;
  localparam int unsigned TRI_W        = $clog2(NUM_TRI);
  localparam int unsigned P_WIDTH      = 16;
  localparam int unsigned C_WIDTH      = 18;
  localparam int unsigned V_WIDTH      = 16;
  localparam int unsigned BRAM_LATENCY = 2;

  typedef logic [TRI_W-1:0]     tri_id_t;
  // One extra bit so a full NUM_TRI frame never wraps the counter.
  typedef logic [TRI_W:0]       tri_cnt_t;
  typedef logic [3*P_WIDTH-1:0] vertex_t;
  typedef vertex_t [2:0]        tri_vertices_t;
  typedef logic [3*C_WIDTH-1:0] cam_ctr_t;
  typedef logic [3*V_WIDTH-1:0] cam_vec_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StPresent,
    StDone
  } sched_state_e;

  function automatic tri_cnt_t clamp_num_tri(input tri_cnt_t n);
    return (n > tri_cnt_t'(NUM_TRI)) ? tri_cnt_t'(NUM_TRI) : n;
  endfunction

endpackage

// File: rtl/tri_frame_scheduler_if.sv
// Triangle output channel: valid/ready handshake carrying ID and vertex data.
interface tri_frame_scheduler_if;
  import tri_frame_scheduler_pkg::*;

  logic          valid;
  logic          ready;
  tri_id_t       tri_id;
  tri_vertices_t p;

  modport master (output valid, output tri_id, output p, input ready);
  modport slave  (input valid, input tri_id, input p, output ready);

endinterface

// File: rtl/tri_frame_scheduler_cam_latch.sv
// Load-enabled register bank for the camera center and basis, cleared by reset.
module tri_frame_scheduler_cam_latch
  import tri_frame_scheduler_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     load_i,
  input  cam_ctr_t c_i,
  input  cam_vec_t u_i,
  input  cam_vec_t v_i,
  input  cam_vec_t n_i,
  output cam_ctr_t c_o,
  output cam_vec_t u_o,
  output cam_vec_t v_o,
  output cam_vec_t n_o
);

  cam_ctr_t c_q;
  cam_vec_t u_q, v_q, n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q <= '0;
      u_q <= '0;
      v_q <= '0;
      n_q <= '0;
    end else if (load_i) begin
      c_q <= c_i;
      u_q <= u_i;
      v_q <= v_i;
      n_q <= n_i;
    end
  end

  assign c_o = c_q;
  assign u_o = u_q;
  assign v_o = v_q;
  assign n_o = n_q;

endmodule

// File: rtl/tri_frame_scheduler.sv
// Per-frame sequencer: latches the camera, fetches each triangle's vertices from BRAM
// and presents them one at a time on a valid/ready channel.
module tri_frame_scheduler
  import tri_frame_scheduler_pkg::*;
#(
  parameter int unsigned BramLatency = BRAM_LATENCY
) (
  input  logic          clk_in,
  input  logic          rst_in_n,
  input  logic          frame_start_in,
  input  tri_cnt_t      num_tri_in,
  input  cam_ctr_t      C_in,
  input  cam_vec_t      u_in,
  input  cam_vec_t      v_in,
  input  cam_vec_t      n_in,
  output tri_id_t       vtx_addr_out,
  input  tri_vertices_t vtx_data_in,
  output cam_ctr_t      C_out,
  output cam_vec_t      u_out,
  output cam_vec_t      v_out,
  output cam_vec_t      n_out,
  output logic          busy_out,
  output logic          frame_done_out,
  tri_frame_scheduler_if.master out_if
);

  localparam int unsigned WaitW = (BramLatency > 1) ? $clog2(BramLatency) : 1;
  typedef logic [WaitW-1:0] wait_t;

  sched_state_e  state_q;
  tri_cnt_t      cnt_q;
  tri_cnt_t      num_tri_q;
  wait_t         wait_q;
  tri_id_t       addr_q;
  tri_id_t       tri_id_q;
  tri_vertices_t p_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic          cam_load;

  assign cam_load = (state_q == StIdle) && frame_start_in;

  tri_frame_scheduler_cam_latch u_cam_latch (
    .clk_i  (clk_in),
    .rst_ni (rst_in_n),
    .load_i (cam_load),
    .c_i    (C_in),
    .u_i    (u_in),
    .v_i    (v_in),
    .n_i    (n_in),
    .c_o    (C_out),
    .u_o    (u_out),
    .v_o    (v_out),
    .n_o    (n_out)
  );

  // The BRAM address is updated on entry to StIssue so it is stable for the whole
  // ISSUE cycle; data is then captured BramLatency+1 cycles later.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      num_tri_q <= '0;
      wait_q    <= '0;
      addr_q    <= '0;
      tri_id_q  <= '0;
      p_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start_in) begin
            num_tri_q <= clamp_num_tri(num_tri_in);
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (num_tri_in != '0) begin
              addr_q  <= '0;
              state_q <= StIssue;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StIssue: begin
          wait_q  <= wait_t'(BramLatency - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == '0) begin
            p_q      <= vtx_data_in;
            tri_id_q <= tri_id_t'(cnt_q);
            valid_q  <= 1'b1;
            state_q  <= StPresent;
          end else begin
            wait_q <= wait_q - wait_t'(1);
          end
        end
        StPresent: begin
          if (out_if.ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + tri_cnt_t'(1);
            if (cnt_q == num_tri_q - tri_cnt_t'(1)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              addr_q  <= tri_id_t'(cnt_q + tri_cnt_t'(1));
              state_q <= StIssue;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vtx_addr_out   = addr_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign out_if.valid   = valid_q;
  assign out_if.tri_id  = tri_id_q;
  assign out_if.p       = p_q;

endmodule

// File: tb/tb_tri_frame_scheduler.sv
// Bench for tri_frame_scheduler: timing-rule model checked every cycle plus directed checks.
module tb_tri_frame_scheduler;
  import tri_frame_scheduler_pkg::*;

  localparam int L = int'(BRAM_LATENCY);
  localparam int NT = int'(NUM_TRI);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  tri_cnt_t               num_tri = '0;
  cam_ctr_t               c_in = '0;
  cam_vec_t               u_in = '0, v_in = '0, n_in = '0;
  tri_id_t                addr;
  logic [9*P_WIDTH-1:0]   bram_s1 = '0, bram_q = '0;
  cam_ctr_t               c_out;
  cam_vec_t               u_out, v_out, n_out;
  logic                   busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  tri_frame_scheduler_if out_if ();

  always #5 clk = ~clk;

  tri_frame_scheduler dut (
    .clk_in         (clk),
    .rst_in_n       (rst_n),
    .frame_start_in (start),
    .num_tri_in     (num_tri),
    .C_in           (c_in),
    .u_in           (u_in),
    .v_in           (v_in),
    .n_in           (n_in),
    .vtx_addr_out   (addr),
    .vtx_data_in    (bram_q),
    .C_out          (c_out),
    .u_out          (u_out),
    .v_out          (v_out),
    .n_out          (n_out),
    .busy_out       (busy),
    .frame_done_out (done),
    .out_if         (out_if)
  );

  // Vertex field j of triangle id is (id*16 + j) ^ 0xA000.
  function automatic logic [9*P_WIDTH-1:0] vtx_of(input int id);
    logic [9*P_WIDTH-1:0] r;
    for (int j = 0; j < 9; j++) r[j*P_WIDTH +: P_WIDTH] = P_WIDTH'(id * 16 + j) ^ 16'hA000;
    return r;
  endfunction

  // Two-stage synchronous-read BRAM.
  always @(posedge clk) begin
    bram_s1 <= vtx_of(int'(addr));
    bram_q  <= bram_s1;
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic expect_true(input string name, input logic cond);
    n_tests++;
    if (cond !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: actual 0 required 1", name);
    end
  endtask

  // Model: a triangle becomes valid L+2 edges after the accepting or transferring edge
  // (counting that edge); done follows the last transfer by one edge.
  int       cyc = 0;
  logic     m_busy = 0, m_valid = 0, m_done = 0;
  int       m_id = 0, m_num = 0, m_timer = 0;
  cam_ctr_t m_c = '0;
  cam_vec_t m_u = '0, m_v = '0, m_n = '0;

  int start_cyc = 0, first_valid_cyc = -1, done_cyc = -1, last_xfer_cyc = -1;
  int xfer_cnt = 0, last_id = -1, busy_cnt = 0;
  logic [P_WIDTH-1:0] p_id1_x = '0, p_id2_top = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_id = 0; m_num = 0; m_timer = 0;
      m_c = '0; m_u = '0; m_v = '0; m_n = '0;
    end else begin
      check("valid", 160'(out_if.valid), 160'(m_valid));
      if (m_valid) begin
        check("tri_id", 160'(out_if.tri_id), 160'(m_id));
        check("P", 160'(out_if.p), 160'(vtx_of(m_id)));
      end
      check("busy", 160'(busy), 160'(m_busy));
      check("frame_done", 160'(done), 160'(m_done));
      check("C", 160'(c_out), 160'(m_c));
      check("u", 160'(u_out), 160'(m_u));
      check("v", 160'(v_out), 160'(m_v));
      check("n", 160'(n_out), 160'(m_n));

      if (out_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_if.valid && out_if.tri_id == tri_id_t'(1)) p_id1_x = out_if.p[0][P_WIDTH-1:0];
      if (out_if.valid && out_if.tri_id == tri_id_t'(2)) p_id2_top = out_if.p[2][3*P_WIDTH-1 -: P_WIDTH];
      if (out_if.valid && out_if.ready) begin
        xfer_cnt++;
        last_id = int'(out_if.tri_id);
        last_xfer_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      if (busy) busy_cnt++;

      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          start_cyc = cyc; first_valid_cyc = -1; done_cyc = -1; last_xfer_cyc = -1;
          xfer_cnt = 0; last_id = -1; busy_cnt = 0;
          m_c = c_in; m_u = u_in; m_v = v_in; m_n = n_in;
          m_num = (int'(num_tri) > NT) ? NT : int'(num_tri);
          m_busy = 1;
          m_id = 0;
          if (m_num == 0) m_done = 1;
          else m_timer = L + 2;
        end
      end else if (m_valid && out_if.ready) begin
        m_valid = 0;
        m_id++;
        if (m_id == m_num) m_done = 1;
        else m_timer = L + 2;
      end
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) m_valid = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    num_tri = tri_cnt_t'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    expect_true("frame_done_seen", done);
    tick();
  endtask

  task automatic wait_valid_id(input int id, input int budget);
    int k = 0;
    while (!(out_if.valid && out_if.tri_id == tri_id_t'(id)) && k < budget) begin
      tick();
      k++;
    end
    expect_true("valid_seen", out_if.valid && out_if.tri_id == tri_id_t'(id));
  endtask

  initial begin
    out_if.ready = 1'b1;
    #3;
    check("rst_valid", 160'(out_if.valid), 160'(0));
    check("rst_tri_id", 160'(out_if.tri_id), 160'(0));
    check("rst_P", 160'(out_if.p), 160'(0));
    check("rst_addr", 160'(addr), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_done", 160'(done), 160'(0));
    check("rst_C", 160'(c_out), 160'(0));
    check("rst_n_out", 160'(n_out), 160'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three triangles, always ready.
    c_in = 54'h12_3456_789A_BCDE; u_in = 48'h0102_0304_0506;
    v_in = 48'h0A0B_0C0D_0E0F;    n_in = 48'h1111_2222_3333;
    start_frame(3);
    wait_done(100);
    check("t1_first_valid_lat", 160'(first_valid_cyc - start_cyc), 160'(4));
    check("t1_xfers", 160'(xfer_cnt), 160'(3));
    check("t1_last_id", 160'(last_id), 160'(2));
    check("t1_done_after_xfer", 160'(done_cyc - last_xfer_cyc), 160'(1));
    check("t1_busy_low", 160'(busy), 160'(0));
    check("t1_p1_x", 160'(p_id1_x), 160'(16'hA010));
    check("t1_p2_top", 160'(p_id2_top), 160'(16'hA028));

    // Backpressure: ready low for 5 cycles while triangle 0 is presented.
    out_if.ready = 1'b0;
    start_frame(2);
    wait_valid_id(0, 20);
    repeat (5) tick();
    out_if.ready = 1'b1;
    wait_done(100);
    check("t2_xfers", 160'(xfer_cnt), 160'(2));
    check("t2_last_id", 160'(last_id), 160'(1));

    // Empty frame.
    start_frame(0);
    wait_done(10);
    check("t3_busy_cycles", 160'(busy_cnt), 160'(1));
    check("t3_no_valid", 160'(first_valid_cyc), 160'(-1));
    check("t3_done_lat", 160'(done_cyc - start_cyc), 160'(1));

    // Mid-frame restart and camera change are ignored.
    start_frame(4);
    repeat (3) tick();
    c_in = 54'h3F_0000_1111_2222;
    n_in = 48'hAAAA_BBBB_CCCC;
    start_frame(1);
    wait_done(200);
    check("t4_C_kept", 160'(c_out), 160'(54'h12_3456_789A_BCDE));
    check("t4_n_kept", 160'(n_out), 160'(48'h1111_2222_3333));
    check("t4_xfers", 160'(xfer_cnt), 160'(4));
    start_frame(1);
    wait_done(50);
    check("t4_C_new", 160'(c_out), 160'(54'h3F_0000_1111_2222));
    check("t4_n_new", 160'(n_out), 160'(48'hAAAA_BBBB_CCCC));
    check("t4_xfers_new", 160'(xfer_cnt), 160'(1));

    // Reset while triangle 5 of 10 is presented.
    start_frame(10);
    wait_valid_id(5, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid_drop", 160'(out_if.valid), 160'(0));
    check("t5_busy_drop", 160'(busy), 160'(0));
    check("t5_done_low", 160'(done), 160'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(2);
    wait_done(100);
    check("t5_restart_xfers", 160'(xfer_cnt), 160'(2));
    check("t5_restart_last", 160'(last_id), 160'(1));

    // Full-size frame with random backpressure.
    begin
      int k = 0;
      start_frame(NT);
      while (!done && k < 60000) begin
        out_if.ready = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      expect_true("t6_done_seen", done);
      out_if.ready = 1'b1;
      tick();
    end
    check("t6_xfers", 160'(xfer_cnt), 160'(NT));
    check("t6_last_id", 160'(last_id), 160'(NT - 1));

    // Oversized count clamps to NUM_TRI.
    start_frame(3000);
    wait_done(20000);
    check("t7_clamp_xfers", 160'(xfer_cnt), 160'(NT));
    check("t7_clamp_last", 160'(last_id), 160'(NT - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_frame_scheduler.md
Name: tri_frame_scheduler

Overview:
- Per-frame sequencer that sits in front of the vertex pre-processing and shading stage.
- On a frame start it snapshots the camera basis.
- It then walks triangle IDs 0..N-1, reads each triangle's three vertices from a synchronous-read vertex BRAM, and presents one triangle at a time on a valid/ready output.
- It signals frame completion once the last triangle has been accepted downstream.

Parameters:
- NUM_TRI, 2048, maximum triangles per frame; ID width TRI_W = $clog2(NUM_TRI).
- P_WIDTH, 16, width of one vertex coordinate.
- C_WIDTH, 18, width of one camera-center coordinate.
- V_WIDTH, 16, width of one camera basis-vector component.
- BRAM_LATENCY, 2, cycles from addr to valid data on vtx_data_in (>=1).

Ports:
- clk_in  in  1  clock.
- rst_in_n  in  1  asynchronous active-low reset.
- frame_start_in  in  1  single-cycle start pulse.
- num_tri_in  in  TRI_W+1  triangle count for the frame; sampled on accepted start.
- C_in  in  3*C_WIDTH  camera center; sampled on accepted start.
- u_in, v_in, n_in  in  3*V_WIDTH each  camera basis; sampled on accepted start.
- vtx_addr_out  out  TRI_W  BRAM read address (= triangle ID).
- vtx_data_in  in  9*P_WIDTH  three vertices {P2,P1,P0}, each {z,y,x}.
- valid_out  out  1  triangle valid to the pre-proc/shader stage.
- ready_in  in  1  downstream ready.
- tri_id_out  out  TRI_W  ID of the presented triangle.
- P_out  out  9*P_WIDTH  registered vertex data.
- C_out  out  3*C_WIDTH  latched camera center, stable for the whole frame.
- u_out, v_out, n_out  out  3*V_WIDTH each  latched basis, stable for the whole frame.
- busy_out  out  1  high from accepted start until frame_done.
- frame_done_out  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0, including the camera latches, vtx_addr_out, P_out, tri_id_out, valid_out, busy_out and frame_done_out.
- Transfer rule: a triangle transfers on a cycle where valid_out && ready_in.
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - frame_start_in=1 latches num_tri, C, u, v, n.
  - Clears tri counter to 0 and sets busy_out=1.
  - Goes to ISSUE if num_tri_in!=0, else DONE.
- ISSUE:
  - Drives vtx_addr_out=counter and loads the wait counter with BRAM_LATENCY-1.
  - Goes to WAIT.
- WAIT:
  - Decrements the wait counter.
  - At 0: captures vtx_data_in into P_out, sets tri_id_out=counter and valid_out=1, goes to PRESENT.
  - Total ISSUE-to-valid_out latency is BRAM_LATENCY+1 cycles.
- PRESENT:
  - valid_out, P_out and tri_id_out are held stable until ready_in (AXI rule: valid never drops before transfer).
  - On transfer: valid_out<=0 and counter increments.
  - If counter==num_tri-1 go to DONE, else go to ISSUE.
  - No back-to-back overlap: at most one triangle is outstanding.
- DONE:
  - frame_done_out=1 for exactly one cycle; busy_out<=0; go to IDLE.
  - A frame_start_in in this cycle is ignored.
- frame_start_in while busy: ignored. Latched camera values and counter are unchanged.
- num_tri_in > NUM_TRI: clamped to NUM_TRI.
- vtx_addr_out holds its last value outside ISSUE/WAIT.
- Reset mid-frame: immediate abort to IDLE.
  - No frame_done pulse.
  - valid_out drops asynchronously.
  - Downstream must tolerate the lost transfer.
- ready_in high while valid_out low: no effect.
- Counter width is TRI_W+1 so that a full NUM_TRI frame never wraps.

Decomposition:
- Shared graphics package: tri_id_t (TRI_W bits), vertex_t (3×P_WIDTH packed), tri_vertices_t (3×vertex_t), cam_vec_t, and the scheduler state enum.
- One natural sub-module: cam_latch, a load-enabled register bank for C/u/v/n with async active-low clear, reusable by the rasteriser's per-frame setup.
- The FSM, counters and output registers stay in the top.

Test Plan:
- num_tri=3, BRAM model with latency 2 holding distinct patterns, ready_in always 1 -> IDs 0,1,2 presented in order with matching P_out; first valid_out 4 cycles after start (1 cycle IDLE→ISSUE + BRAM_LATENCY+1); frame_done one cycle after the 3rd transfer; busy deasserts with it.
- num_tri=2, ready_in low for 5 cycles while valid_out is high -> valid_out, P_out and tri_id_out stable throughout; transfer on ready; no skipped or duplicated IDs.
- num_tri=0 -> no valid_out; frame_done 1 cycle after start; busy high exactly 1 cycle.
- Second frame_start and changed C_in/n_in mid-frame -> C_out/n_out keep first-frame values; frame completes with the original count; a new start after done latches the new values.
- Assert rst_in_n=0 during PRESENT of triangle 5 of 10 -> valid_out=0 immediately; no frame_done; a restart begins again at ID 0.
- num_tri=NUM_TRI, random ready_in -> exactly NUM_TRI transfers, last tri_id_out=NUM_TRI-1, no counter wrap.
